// File: rtl/game_scoreboard.sv
// Match scoreboard for a round-based game: loads the game each round, tallies
// winner/loser rounds on gameover edges and declares a match winner.
module game_scoreboard #(
    parameter int ROUNDS_TO_WIN = 3,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] seed,
    input  logic       gameover,
    input  logic [1:0] who,
    output logic       init,
    output logic [3:0] initial_val,
    output logic [2:0] win_score,
    output logic [2:0] lose_score,
    output logic [3:0] round_cnt,
    output logic       match_over,
    output logic [1:0] match_winner,
    output logic       busy,
    output logic       proto_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [2:0] WIN_TARGET = 3'(ROUNDS_TO_WIN);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

    state_t     state_q;
    logic       gameover_q;
    logic [7:0] hold_cnt_q;
    logic       go_event;
    logic [2:0] win_inc;
    logic [2:0] lose_inc;
    logic [3:0] rnd_inc;

    assign go_event = gameover & ~gameover_q;
    assign win_inc  = win_score + 3'd1;
    assign lose_inc = lose_score + 3'd1;
    assign rnd_inc  = (round_cnt == 4'hF) ? 4'hF : round_cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gameover_q   <= 1'b0;
            hold_cnt_q   <= 8'd0;
            init         <= 1'b0;
            initial_val  <= 4'd0;
            win_score    <= 3'd0;
            lose_score   <= 3'd0;
            round_cnt    <= 4'd0;
            match_over   <= 1'b0;
            match_winner <= 2'd0;
            busy         <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            gameover_q <= gameover;
            init       <= 1'b0;
            case (state_q)
                // A fresh match can start from IDLE or after a finished match;
                // any coincident gameover edge is simply dropped.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        initial_val  <= seed;
                        win_score    <= 3'd0;
                        lose_score   <= 3'd0;
                        round_cnt    <= 4'd0;
                        proto_err    <= 1'b0;
                        match_winner <= 2'd0;
                        match_over   <= 1'b0;
                        busy         <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    init    <= 1'b1;
                    state_q <= S_PLAY;
                end
                S_PLAY: begin
                    if (go_event) begin
                        if (who == 2'd2) begin
                            win_score  <= win_inc;
                            round_cnt  <= rnd_inc;
                            hold_cnt_q <= 8'd0;
                            if (win_inc == WIN_TARGET) begin
                                match_winner <= 2'd2;
                                match_over   <= 1'b1;
                                busy         <= 1'b0;
                                state_q      <= S_DONE;
                            end else begin
                                state_q <= S_HOLD;
                            end
                        end else if (who == 2'd1) begin
                            lose_score <= lose_inc;
                            round_cnt  <= rnd_inc;
                            hold_cnt_q <= 8'd0;
                            if (lose_inc == WIN_TARGET) begin
                                match_winner <= 2'd1;
                                match_over   <= 1'b1;
                                busy         <= 1'b0;
                                state_q      <= S_DONE;
                            end else begin
                                state_q <= S_HOLD;
                            end
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= S_LOAD;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_scoreboard.sv
// Randomised self-checking bench for game_scoreboard against a match-level
// reference model (scores, rounds and winner computed from the game rules).
module tb_game_scoreboard;

    localparam int R = 3;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] seed = 4'd0;
    logic       gameover = 1'b0;
    logic [1:0] who = 2'd0;
    logic       init;
    logic [3:0] initial_val;
    logic [2:0] win_score;
    logic [2:0] lose_score;
    logic [3:0] round_cnt;
    logic       match_over;
    logic [1:0] match_winner;
    logic       busy;
    logic       proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    game_scoreboard #(.ROUNDS_TO_WIN(R), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .gameover(gameover), .who(who), .init(init),
        .initial_val(initial_val), .win_score(win_score),
        .lose_score(lose_score), .round_cnt(round_cnt),
        .match_over(match_over), .match_winner(match_winner),
        .busy(busy), .proto_err(proto_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One gameover pulse held for 'hold' cycles; snapshots outputs right after the event edge.
    task automatic play_round(input logic [1:0] w, input int hold,
                              output logic [2:0] ws, output logic [2:0] ls,
                              output logic [3:0] rc, output logic pe);
        gameover = 1'b1;
        who      = w;
        cyc();
        ws = win_score;
        ls = lose_score;
        rc = round_cnt;
        pe = proto_err;
        for (int i = 1; i < hold; i++) cyc();
        gameover = 1'b0;
        who      = 2'd0;
        $display("round who=%0d win=%0d lose=%0d rounds=%0d perr=%0d", w, ws, ls, rc, pe);
    endtask

    // Cycles until init is seen high; -1 if the budget runs out.
    task automatic wait_init(output int n);
        n = -1;
        for (int i = 1; i <= 4 * H + 8; i++) begin
            cyc();
            if (init === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        gameover = 1'b1;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({init, initial_val, win_score, lose_score, round_cnt, match_over,
             match_winner, busy, proto_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got init=%b iv=%0d ws=%0d ls=%0d rc=%0d mo=%b mw=%0d busy=%b pe=%b, need all 0",
                     init, initial_val, win_score, lose_score, round_cnt, match_over,
                     match_winner, busy, proto_err);
        end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if ({init, win_score, lose_score, round_cnt, busy, proto_err} !== '0) begin
            n_bad++;
            $display("FAIL gameover_at_release: init=%b ws=%0d ls=%0d rc=%0d busy=%b pe=%b, need all 0",
                     init, win_score, lose_score, round_cnt, busy, proto_err);
        end
        gameover = 1'b0;
        cyc();
    endtask

    task automatic test_first_round();
        int inits;
        seed  = 4'd5;
        start = 1'b1;
        cyc();
        start = 1'b0;
        seed  = 4'd0;
        n_cmp++;
        if (init !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_edge: init=%b busy=%b, need init=0 busy=1", init, busy);
        end
        cyc();
        n_cmp++;
        if (init !== 1'b1 || initial_val !== 4'd5) begin
            n_bad++;
            $display("FAIL init_pulse: init=%b iv=%0d, need init=1 iv=5", init, initial_val);
        end
        cyc();
        n_cmp++;
        if (init !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL init_width: init=%b busy=%b, need init=0 busy=1", init, busy);
        end
        // start in PLAY must not produce another load
        inits = 0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (init === 1'b1) inits++;
        end
        start = 1'b0;
        n_cmp++;
        if (inits != 0 || round_cnt !== 4'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_in_play: inits=%0d rc=%0d busy=%b, need 0/0/1", inits, round_cnt, busy);
        end
    endtask

    task automatic test_win_match();
        logic [2:0] ws, ls;
        logic [3:0] rc;
        logic       pe;
        int         n;
        for (int i = 0; i < R; i++) begin
            play_round(2'd2, 3, ws, ls, rc, pe);
            n_cmp++;
            if (ws !== 3'(i + 1) || ls !== 3'd0 || rc !== 4'(i + 1)) begin
                n_bad++;
                $display("FAIL win_round%0d: ws=%0d ls=%0d rc=%0d, need %0d/0/%0d", i, ws, ls, rc, i + 1, i + 1);
            end
            if (i == 0) begin
                // stray pulse in HOLD is discarded
                cyc();
                gameover = 1'b1;
                who      = 2'd2;
                cyc();
                gameover = 1'b0;
                n_cmp++;
                if (win_score !== 3'd1 || round_cnt !== 4'd1 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL pulse_in_hold: ws=%0d rc=%0d busy=%b, need 1/1/1", win_score, round_cnt, busy);
                end
                wait_init(n);
                n_cmp++;
                if (n != H + 1 - 4) begin
                    n_bad++;
                    $display("FAIL hold_len_r0: got %0d more cycles to init, need %0d", n, H + 1 - 4);
                end
            end else if (i < R - 1) begin
                wait_init(n);
                n_cmp++;
                if (n != H + 1 - 2) begin
                    n_bad++;
                    $display("FAIL hold_len_r%0d: got %0d more cycles to init, need %0d", i, n, H + 1 - 2);
                end
            end
        end
        n_cmp++;
        if (match_over !== 1'b1 || match_winner !== 2'd2 || busy !== 1'b0 || initial_val !== 4'd5) begin
            n_bad++;
            $display("FAIL win_match_end: mo=%b mw=%0d busy=%b iv=%0d, need 1/2/0/5",
                     match_over, match_winner, busy, initial_val);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] seq [5];
        logic [2:0] ws, ls;
        logic [3:0] rc;
        logic       pe;
        int         n;
        seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        seed  = 4'hF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++;
        if (win_score !== 3'd0 || round_cnt !== 4'd0 || match_over !== 1'b0 || match_winner !== 2'd0) begin
            n_bad++;
            $display("FAIL restart_clear: ws=%0d rc=%0d mo=%b mw=%0d, need all 0",
                     win_score, round_cnt, match_over, match_winner);
        end
        wait_init(n);
        n_cmp++;
        if (n != 1) begin
            n_bad++;
            $display("FAIL restart_init: got init after %0d cycles, need 1", n);
        end
        for (int i = 0; i < 5; i++) begin
            play_round(seq[i], 3, ws, ls, rc, pe);
            if (i < 4) wait_init(n);
        end
        n_cmp++;
        if (ls !== 3'd3 || ws !== 3'd2 || rc !== 4'd5 || match_winner !== 2'd1 || initial_val !== 4'hF) begin
            n_bad++;
            $display("FAIL alternate: ls=%0d ws=%0d rc=%0d mw=%0d iv=%0d, need 3/2/5/1/15",
                     ls, ws, rc, match_winner, initial_val);
        end
    endtask

    task automatic test_proto();
        logic [2:0] ws, ls;
        logic [3:0] rc;
        logic       pe;
        int         n;
        seed  = 4'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_init(n);
        start = 1'b1;
        play_round(2'd0, 3, ws, ls, rc, pe);
        start = 1'b0;
        n_cmp++;
        if (pe !== 1'b1 || ws !== 3'd0 || ls !== 3'd0 || rc !== 4'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL proto_err: pe=%b ws=%0d ls=%0d rc=%0d busy=%b, need 1/0/0/0/1", pe, ws, ls, rc, busy);
        end
        cyc();
        play_round(2'd2, 3, ws, ls, rc, pe);
        n_cmp++;
        if (ws !== 3'd1 || rc !== 4'd1 || pe !== 1'b1) begin
            n_bad++;
            $display("FAIL score_after_err: ws=%0d rc=%0d pe=%b, need 1/1/1", ws, rc, pe);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] ws, ls;
        logic [3:0] rc;
        logic       pe;
        int         n;
        int         act;
        wait_init(n);
        play_round(2'd2, 1, ws, ls, rc, pe);
        cyc();
        n_cmp++;
        if (win_score !== 3'd2 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: ws=%0d busy=%b, need 2/1", win_score, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({init, initial_val, win_score, lose_score, round_cnt, match_over,
             match_winner, busy, proto_err} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: ws=%0d rc=%0d busy=%b pe=%b iv=%0d, need all 0",
                     win_score, round_cnt, busy, proto_err, initial_val);
        end
        cyc();
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < H + 4; i++) begin
            cyc();
            if (busy === 1'b1 || init === 1'b1) act++;
        end
        n_cmp++;
        if (act != 0) begin
            n_bad++;
            $display("FAIL idle_after_reset: %0d active cycles, need 0", act);
        end
        seed  = 4'd9;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_init(n);
        n_cmp++;
        if (n != 1 || round_cnt !== 4'd0 || win_score !== 3'd0 || initial_val !== 4'd9) begin
            n_bad++;
            $display("FAIL fresh_match: n=%0d rc=%0d ws=%0d iv=%0d, need 1/0/0/9", n, round_cnt, win_score, initial_val);
        end
        play_round(2'd1, 3, ws, ls, rc, pe);
        n_cmp++;
        if (ls !== 3'd1 || rc !== 4'd1) begin
            n_bad++;
            $display("FAIL fresh_round: ls=%0d rc=%0d, need 1/1", ls, rc);
        end
    endtask

    task automatic test_random();
        logic [2:0] ws, ls;
        logic [3:0] rc;
        logic       pe;
        int         n, hold, m_ws, m_ls, m_rc, m_pe, events;
        logic [1:0] w;
        logic [3:0] m_seed;
        bit         done;
        #2 rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        for (int m = 0; m < 8; m++) begin
            m_seed = 4'($urandom_range(0, 15));
            seed   = m_seed;
            start  = 1'b1;
            if (m % 2 == 1) begin
                gameover = 1'b1;
                who      = 2'd2;
            end
            cyc();
            start    = 1'b0;
            gameover = 1'b0;
            seed     = ~m_seed;
            n_cmp++;
            if (win_score !== 3'd0 || lose_score !== 3'd0 || round_cnt !== 4'd0 ||
                match_over !== 1'b0 || match_winner !== 2'd0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL rnd_start%0d: ws=%0d ls=%0d rc=%0d mo=%b mw=%0d busy=%b",
                         m, win_score, lose_score, round_cnt, match_over, match_winner, busy);
            end
            wait_init(n);
            m_ws = 0; m_ls = 0; m_rc = 0; m_pe = 0;
            done = 1'b0;
            events = 0;
            while (!done && events < 40) begin
                events++;
                if ($urandom_range(0, 99) < 85) w = 2'($urandom_range(1, 2));
                else w = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
                hold = $urandom_range(1, 4);
                if (w == 2'd1 || w == 2'd2) begin
                    if (w == 2'd2) m_ws++;
                    else m_ls++;
                    m_rc = (m_rc == 15) ? 15 : m_rc + 1;
                    done = (m_ws == R) || (m_ls == R);
                end else begin
                    m_pe  = 1;
                    start = $urandom_range(0, 1);
                end
                play_round(w, hold, ws, ls, rc, pe);
                start = 1'b0;
                n_cmp++;
                if (ws !== 3'(m_ws) || ls !== 3'(m_ls) || rc !== 4'(m_rc) || pe !== 1'(m_pe)) begin
                    n_bad++;
                    $display("FAIL rnd_event m%0d e%0d: ws=%0d ls=%0d rc=%0d pe=%b, need %0d/%0d/%0d/%0d",
                             m, events, ws, ls, rc, pe, m_ws, m_ls, m_rc, m_pe);
                end
                if (w == 2'd0 || w == 2'd3) begin
                    cyc();
                end else if (!done) begin
                    wait_init(n);
                    n_cmp++;
                    if (n + hold - 1 != H + 1) begin
                        n_bad++;
                        $display("FAIL rnd_hold m%0d e%0d: init %0d cycles after event, need %0d",
                                 m, events, n + hold - 1, H + 1);
                    end
                end
            end
            n_cmp++;
            if (match_over !== 1'b1 || busy !== 1'b0 || initial_val !== m_seed ||
                match_winner !== ((m_ws == R) ? 2'd2 : 2'd1)) begin
                n_bad++;
                $display("FAIL rnd_end%0d: mo=%b busy=%b iv=%0d mw=%0d, need 1/0/%0d/%0d",
                         m, match_over, busy, initial_val, match_winner, m_seed,
                         (m_ws == R) ? 2 : 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_win_match();
        test_alternate();
        test_proto();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_scoreboard.md
GAME_SCOREBOARD -- requirements
Module: game_scoreboard

Interface
REQ-001 Parameter: ROUNDS_TO_WIN, default 3, rounds one side needs to take the match; legal 1..7.
REQ-002 Parameter: HOLD_CYCLES, default 8, idle gap between the end of one round and the next init; legal 1..255.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: start  in  1  level, sampled on clk; begins a match.
REQ-006 Port: seed  in  4  round starting value, captured on an accepted start.
REQ-007 Port: gameover  in  1  game-over level from the game.
REQ-008 Port: who  in  2  game result from the game: 1 = loser side, 2 = winner side; 0 and 3 are illegal alongside gameover.
REQ-009 Port: init  out  1  one-cycle load pulse to the game.
REQ-010 Port: initial_val  out  4  registered copy of the captured seed, driven to the game.
REQ-011 Port: win_score  out  3  rounds taken by the winner side.
REQ-012 Port: lose_score  out  3  rounds taken by the loser side.
REQ-013 Port: round_cnt  out  4  rounds completed in this match, saturating.
REQ-014 Port: match_over  out  1  high while in DONE.
REQ-015 Port: match_winner  out  2  0 = none, 1 = loser side, 2 = winner side.
REQ-016 Port: busy  out  1  high in LOAD, PLAY and HOLD.
REQ-017 Port: proto_err  out  1  sticky flag: illegal who seen on a gameover edge.

Function
REQ-018 States SHALL be IDLE, LOAD, PLAY, HOLD and DONE; all outputs SHALL be registered.
REQ-019 A gameover event SHALL be the rising edge of gameover, detected by comparing it with a registered copy of the previous sample (gameover_q); a level held high SHALL produce exactly one event.
REQ-020 IDLE, start=1: capture seed into initial_val, clear the scores, round_cnt and proto_err, and go to LOAD.
REQ-021 LOAD: init=1 for exactly one cycle, then PLAY; with start sampled at edge k, init SHALL be high between edges k+1 and k+2.
REQ-022 PLAY, gameover event with who=2: win_score+1; with who=1: lose_score+1; either way round_cnt+1, saturating at 15; all updates visible after that same edge.
REQ-023 PLAY, gameover event with who=0 or 3: no score change, round_cnt unchanged, proto_err=1 (sticky), stay in PLAY.
REQ-024 After a scoring update, a score equal to ROUNDS_TO_WIN SHALL move to DONE in the same edge, with match_winner set to 1 or 2 accordingly; otherwise the block SHALL go to HOLD.
REQ-025 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to LOAD; initial_val SHALL be unchanged across the whole match.
REQ-026 Gameover events in IDLE, LOAD, HOLD and DONE SHALL be discarded with no side effects; gameover_q SHALL still track the input in every state.
REQ-027 start SHALL be ignored in LOAD, PLAY and HOLD.
REQ-028 DONE: match_over=1 and the scores held; start=1 SHALL clear the scores, round_cnt, match_winner and proto_err, capture seed, and go to LOAD.
REQ-029 DONE, start and a gameover event on the same edge: start wins and the event is discarded.
REQ-030 Scores SHALL never exceed ROUNDS_TO_WIN, since DONE is entered on reaching it.
REQ-031 Any seed value, including 0 and 15, SHALL be accepted unmodified.

Reset
REQ-032 rst=1 SHALL immediately (asynchronously) force IDLE, init=0, initial_val=0, both scores=0, round_cnt=0, match_over=0, match_winner=0, busy=0, proto_err=0 and gameover_q=0.
REQ-033 rst asserted mid-round SHALL abandon the match; on release the block SHALL stay in IDLE until start.
REQ-034 If gameover is already high when rst releases, the first sample SHALL count as an event, but it SHALL be discarded because the block is in IDLE.

Verification
REQ-035 rst released, seed=5, start for 1 cycle -> init high exactly 1 cycle, one cycle after start; initial_val=5; busy=1.
REQ-036 Three gameover pulses with who=2, each held 3 cycles (defaults) -> win_score 1, 2, 3; round_cnt=3; match_over=1; match_winner=2; a HOLD of 8 cycles and an init pulse between rounds.
REQ-037 Alternating who=1, 2, 1, 2, 1 -> lose_score=3, win_score=2, match_winner=1, round_cnt=5.
REQ-038 gameover event with who=0 in PLAY -> proto_err=1, scores unchanged, still PLAY; a later who=2 event still scores.
REQ-039 gameover pulse during HOLD, and start during PLAY -> no score change, no state change, no extra init.
REQ-040 rst asserted in HOLD with win_score=2 -> all outputs 0 with no clock edge; the next start yields a fresh match with round_cnt=0.
